// File: rtl/rei_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rei_pkg
// Description : Shared definitions for the machine-mode CSR file. This package
//               holds the CSR address map, the mstatus bit positions and the
//               misa value, plus a small decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rei_pkg;

    localparam int XLEN = 32;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // User-level read-only counter shadows
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // mstatus fields
    localparam int          MSTATUS_MIE   = 3;
    localparam int          MSTATUS_MPIE  = 7;
    localparam logic [1:0]  MSTATUS_MPP_M = 2'b11;

    // misa: MXL=1 (32-bit), extension I only
    localparam logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100;

    // Addresses with [11:10]==2'b11 are read-only by construction
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter
// Description : 64-bit CSR counter with split low/high write access. A write
//               to either half replaces that half, keeps the other half and
//               blocks the increment for that cycle.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset
//               inc_i    - count enable
//               wlo_i    - write low half with wdata_i
//               whi_i    - write high half with wdata_i
//               wdata_i  - write data
//               count_o  - current 64-bit count
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter
    import rei_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            wlo_i,
    input  logic            whi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [63:0]     count_o
);

    logic [63:0] r_count;
    logic [63:0] w_count_inc;

    // Natural 64-bit wrap; the low half carries into the high half
    assign w_count_inc = r_count + 64'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (wlo_i || whi_i) begin
            if (wlo_i) r_count[31:0]  <= wdata_i;
            if (whi_i) r_count[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_count <= w_count_inc;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : Machine-mode CSR register file for one hart. It provides a
//               combinational read port for the CSR ALU, a commit write port,
//               trap/mret state updates and the mcycle/minstret counters.
// Config      : REI_ZICNTR_EN - when defined, the user read-only counter
//               shadows C00/C01/C02/C80/C81/C82 are readable.
// Parameters  : MTVEC_RST - mtvec reset value (bits [1:0] forced to 0)
//               MHARTID   - value returned by mhartid
// Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//               csr_raddr_i/csr_rwen_i  - read address / write intent
//               csr_rdata_o/csr_ill_o   - read data / illegal access flag
//               csr_we_i/waddr/wdata    - commit write
//               instret_i               - instruction retired
//               trap_i, trap_cause_i, trap_pc_i, trap_tval_i - trap entry
//               mret_i                  - trap return
//               trap_vec_o, epc_o, mie_o - state for the fetch/interrupt logic
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file
    import rei_pkg::*;
#(
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] MHARTID   = '0
)(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     csr_raddr_i,
    input  logic            csr_rwen_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_ill_o,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            instret_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] epc_o,
    output logic            mie_o
);

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [63:0]     w_mcycle;
    logic [63:0]     w_minstret;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_rdata;
    logic            w_known;
    logic            w_we;

    // A trap or mret in the same cycle swallows the commit write completely,
    // including any counter write.
    assign w_we = csr_we_i & ~trap_i & ~mret_i;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    csr_counter u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wlo_i   (w_we && (csr_waddr_i == CSR_MCYCLE)),
        .whi_i   (w_we && (csr_waddr_i == CSR_MCYCLEH)),
        .wdata_i (csr_wdata_i),
        .count_o (w_mcycle)
    );

    csr_counter u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wlo_i   (w_we && (csr_waddr_i == CSR_MINSTRET)),
        .whi_i   (w_we && (csr_waddr_i == CSR_MINSTRETH)),
        .wdata_i (csr_wdata_i),
        .count_o (w_minstret)
    );

    // ------------------------------------------------------------------
    // Machine state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RST & c_align_mask;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (trap_i) begin
            r_mepc     <= trap_pc_i & c_align_mask;
            r_mcause   <= trap_cause_i;
            r_mtval    <= trap_tval_i;
            r_mpie     <= r_mie;
            r_mie      <= 1'b0;
        end else if (mret_i) begin
            r_mie      <= r_mpie;
            r_mpie     <= 1'b1;
        end else if (csr_we_i) begin
            case (csr_waddr_i)
                CSR_MSTATUS: begin
                    r_mie  <= csr_wdata_i[MSTATUS_MIE];
                    r_mpie <= csr_wdata_i[MSTATUS_MPIE];
                end
                CSR_MTVEC:    r_mtvec    <= csr_wdata_i & c_align_mask;
                CSR_MSCRATCH: r_mscratch <= csr_wdata_i;
                CSR_MEPC:     r_mepc     <= csr_wdata_i & c_align_mask;
                CSR_MCAUSE:   r_mcause   <= csr_wdata_i;
                CSR_MTVAL:    r_mtval    <= csr_wdata_i;
                default:      ;  // counters handled above; RO/unknown ignored
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        w_mstatus                = '0;
        w_mstatus[12:11]         = MSTATUS_MPP_M;
        w_mstatus[MSTATUS_MPIE]  = r_mpie;
        w_mstatus[MSTATUS_MIE]   = r_mie;
    end

    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        case (csr_raddr_i)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MISA:      w_rdata = MISA_VAL;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:   w_rdata = MHARTID;
`ifdef REI_ZICNTR_EN
            // time has no separate timer here; it mirrors mcycle
            CSR_CYCLE,
            CSR_TIME:      w_rdata = w_mcycle[31:0];
            CSR_CYCLEH,
            CSR_TIMEH:     w_rdata = w_mcycle[63:32];
            CSR_INSTRET:   w_rdata = w_minstret[31:0];
            CSR_INSTRETH:  w_rdata = w_minstret[63:32];
`endif
            default:       w_known = 1'b0;
        endcase
    end

    assign csr_rdata_o = w_rdata;
    assign csr_ill_o   = ~w_known | (csr_rwen_i & csr_is_ro(csr_raddr_i));

    assign trap_vec_o  = r_mtvec;
    assign epc_o       = r_mepc;
    assign mie_o       = r_mie;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Self-checking bench for csr_file. Read expectations are queued
//               when a read address is driven and retired against the DUT
//               read port once it has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] c_mtvec_rst = 32'h0000_1003;
    localparam logic [31:0] c_hartid    = 32'h0000_0007;
`ifdef REI_ZICNTR_EN
    localparam bit c_zc = 1'b1;
`else
    localparam bit c_zc = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_raddr = '0;
    logic        csr_rwen  = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_ill;
    logic        csr_we    = 1'b0;
    logic [11:0] csr_waddr = '0;
    logic [31:0] csr_wdata = '0;
    logic        instret   = 1'b0;
    logic        trap      = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc    = '0;
    logic [31:0] trap_tval  = '0;
    logic        mret      = 1'b0;
    logic [31:0] trap_vec;
    logic [31:0] epc;
    logic        mie;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    csr_file #(
        .MTVEC_RST (c_mtvec_rst),
        .MHARTID   (c_hartid)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .csr_raddr_i  (csr_raddr),
        .csr_rwen_i   (csr_rwen),
        .csr_rdata_o  (csr_rdata),
        .csr_ill_o    (csr_ill),
        .csr_we_i     (csr_we),
        .csr_waddr_i  (csr_waddr),
        .csr_wdata_i  (csr_wdata),
        .instret_i    (instret),
        .trap_i       (trap),
        .trap_cause_i (trap_cause),
        .trap_pc_i    (trap_pc),
        .trap_tval_i  (trap_tval),
        .mret_i       (mret),
        .trap_vec_o   (trap_vec),
        .epc_o        (epc),
        .mie_o        (mie)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational read: queue expectations, let the port settle, retire them
    task automatic rd(input string tag, input logic [11:0] a, input logic rwen,
                      input logic [31:0] d, input logic ill);
        exp_t e;
        csr_raddr = a;
        csr_rwen  = rwen;
        sb_q.push_back('{tag: tag, val: d});
        sb_q.push_back('{tag: {tag, ".ill"}, val: {31'b0, ill}});
        #1;
        e = sb_q.pop_front();
        chk(e.tag, csr_rdata, e.val);
        e = sb_q.pop_front();
        chk(e.tag, {31'b0, csr_ill}, e.val);
        csr_rwen = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        step();
        csr_we    = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) step();
        rst = 1'b0;
        chk("rst.trap_vec", trap_vec, 32'h0000_1000);
        chk("rst.epc", epc, 32'h0);
        chk("rst.mie", {31'b0, mie}, 32'h0);
        rd("rst.mstatus", 12'h300, 1'b0, 32'h0000_1800, 1'b0);
        rd("rst.mtvec",   12'h305, 1'b0, 32'h0000_1000, 1'b0);
        rd("rst.mhartid", 12'hF14, 1'b0, c_hartid,      1'b0);
        rd("rst.misa",    12'h301, 1'b0, 32'h4000_0100, 1'b0);
        rd("rst.mcause",  12'h342, 1'b0, 32'h0,         1'b0);
        rd("rst.minstret",12'hB02, 1'b0, 32'h0,         1'b0);
        step();
        rd("unknown",     12'h7C0, 1'b0, 32'h0,         1'b1);
        rd("rwen.mstatus",12'h300, 1'b1, 32'h0000_1800, 1'b0);
        rd("rwen.misa",   12'h301, 1'b1, 32'h4000_0100, 1'b0);
        rd("rwen.mhartid",12'hF14, 1'b1, c_hartid,      1'b1);

        // ---------------- writes and masks ----------------
        wr(12'h305, 32'h8000_0103);
        chk("mtvec.trap_vec", trap_vec, 32'h8000_0100);
        rd("mtvec.rd", 12'h305, 1'b0, 32'h8000_0100, 1'b0);
        wr(12'h341, 32'h0000_1003);
        chk("mepc.epc", epc, 32'h0000_1000);
        rd("mepc.rd", 12'h341, 1'b0, 32'h0000_1000, 1'b0);
        wr(12'h340, 32'hDEAD_BEEF);
        rd("mscratch.rd", 12'h340, 1'b0, 32'hDEAD_BEEF, 1'b0);
        wr(12'h301, 32'h0);
        rd("misa.ro", 12'h301, 1'b0, 32'h4000_0100, 1'b0);
        wr(12'hF14, 32'h0);
        rd("mhartid.ro", 12'hF14, 1'b0, c_hartid, 1'b0);

        // ---------------- trap / mret ----------------
        wr(12'h300, 32'h0000_0008);
        rd("mstatus.mie1", 12'h300, 1'b0, 32'h0000_1808, 1'b0);
        chk("mie_o.set", {31'b0, mie}, 32'h1);
        trap = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'h8000_000B; trap_tval = 32'h0000_0055;
        step();
        trap = 1'b0;
        rd("trap.mepc",    12'h341, 1'b0, 32'h0000_0204, 1'b0);
        rd("trap.mcause",  12'h342, 1'b0, 32'h8000_000B, 1'b0);
        rd("trap.mtval",   12'h343, 1'b0, 32'h0000_0055, 1'b0);
        rd("trap.mstatus", 12'h300, 1'b0, 32'h0000_1880, 1'b0);
        chk("trap.epc", epc, 32'h0000_0204);
        chk("trap.mie_o", {31'b0, mie}, 32'h0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        rd("mret.mstatus", 12'h300, 1'b0, 32'h0000_1888, 1'b0);
        chk("mret.mie_o", {31'b0, mie}, 32'h1);

        wr(12'h300, 32'h0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        rd("mret0.mstatus", 12'h300, 1'b0, 32'h0000_1880, 1'b0);

        // trap beats a same-cycle commit to mepc
        trap = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'h0000_0002; trap_tval = 32'h0;
        csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h0000_1234;
        step();
        trap = 1'b0; csr_we = 1'b0;
        rd("trapwe.mepc",   12'h341, 1'b0, 32'h0000_0300, 1'b0);
        rd("trapwe.mcause", 12'h342, 1'b0, 32'h0000_0002, 1'b0);
        rd("trapwe.mstatus",12'h300, 1'b0, 32'h0000_1800, 1'b0);

        // mret beats a same-cycle commit to mscratch
        mret = 1'b1;
        csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h0000_00AA;
        step();
        mret = 1'b0; csr_we = 1'b0;
        rd("mretwe.mscratch", 12'h340, 1'b0, 32'hDEAD_BEEF, 1'b0);
        rd("mretwe.mstatus",  12'h300, 1'b0, 32'h0000_1880, 1'b0);

        // trap beats a same-cycle mret
        trap = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0400; trap_cause = 32'h0000_0003;
        step();
        trap = 1'b0; mret = 1'b0;
        rd("trapmret.mepc",    12'h341, 1'b0, 32'h0000_0400, 1'b0);
        rd("trapmret.mstatus", 12'h300, 1'b0, 32'h0000_1800, 1'b0);

        // ---------------- minstret ----------------
        instret = 1'b1;
        wr(12'hB82, 32'h0000_0005);
        rd("minstreth.wr", 12'hB82, 1'b0, 32'h0000_0005, 1'b0);
        rd("minstret.noinc", 12'hB02, 1'b0, 32'h0, 1'b0);
        step();
        instret = 1'b0;
        rd("minstret.inc", 12'hB02, 1'b0, 32'h0000_0001, 1'b0);
        step();
        rd("minstret.hold", 12'hB02, 1'b0, 32'h0000_0001, 1'b0);

        // ---------------- mcycle carry and wrap ----------------
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycle.wr",  12'hB00, 1'b0, 32'hFFFF_FFFF, 1'b0);
        rd("mcycleh.pre",12'hB80, 1'b0, 32'h0,         1'b0);
        step();
        rd("mcycle.carry",  12'hB00, 1'b0, 32'h0,         1'b0);
        rd("mcycleh.carry", 12'hB80, 1'b0, 32'h0000_0001, 1'b0);

        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("wrap.pre.lo", 12'hB00, 1'b0, 32'hFFFF_FFFF, 1'b0);
        rd("wrap.pre.hi", 12'hB80, 1'b0, 32'hFFFF_FFFF, 1'b0);
        step();
        rd("wrap.lo", 12'hB00, 1'b0, 32'h0, 1'b0);
        rd("wrap.hi", 12'hB80, 1'b0, 32'h0, 1'b0);

        // ---------------- user counter shadows ----------------
        rd("zc.cycle0",  12'hC00, 1'b0, 32'h0, !c_zc);
        rd("zc.cycleh0", 12'hC80, 1'b0, 32'h0, !c_zc);
        step();
        rd("zc.cycle1",   12'hC00, 1'b0, c_zc ? 32'h1 : 32'h0, !c_zc);
        rd("zc.time1",    12'hC01, 1'b0, c_zc ? 32'h1 : 32'h0, !c_zc);
        rd("mcycle.1",    12'hB00, 1'b0, 32'h1, 1'b0);
        rd("zc.instret",  12'hC02, 1'b0, c_zc ? 32'h1 : 32'h0, !c_zc);
        rd("zc.instreth", 12'hC82, 1'b0, c_zc ? 32'h5 : 32'h0, !c_zc);
        rd("zc.instret.rwen", 12'hC02, 1'b1, c_zc ? 32'h1 : 32'h0, 1'b1);

        // ---------------- reset mid-run ----------------
        rst = 1'b1;
        csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h1;
        step();
        rst = 1'b0; csr_we = 1'b0;
        rd("rerst.mscratch", 12'h340, 1'b0, 32'h0, 1'b0);
        rd("rerst.minstret", 12'hB02, 1'b0, 32'h0, 1'b0);
        chk("rerst.trap_vec", trap_vec, 32'h0000_1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
